// File: rtl/tq_mode_dispatch_if.sv
// rtl/tq_mode_dispatch_if.sv - row stream and per-engine handshake bundle for tq_mode_dispatch
interface tq_mode_dispatch_if #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 256,
    parameter int CH_W   = 3
);
    logic              i_valid;
    logic [DATA_W-1:0] i_data;
    logic [CH_W-1:0]   i_ch;
    logic [1:0]        i_size;
    logic              o_ready;
    logic [NUM_CH-1:0] o_valid;
    logic [DATA_W-1:0] o_data;
    logic              o_last;
    logic [NUM_CH-1:0] i_ready;

    modport master (
        output i_valid, i_data, i_ch, i_size, i_ready,
        input  o_ready, o_valid, o_data, o_last
    );

    modport slave (
        input  i_valid, i_data, i_ch, i_size, i_ready,
        output o_ready, o_valid, o_data, o_last
    );
endinterface

// File: rtl/tq_mode_dispatch.sv
// rtl/tq_mode_dispatch.sv - block-locked row steering to NUM_CH transform engines, registered output
// Optional illegal-channel check enabled by TQ_DISPATCH_CHK_EN.
module tq_mode_dispatch #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 256,
    parameter int CH_W   = 3
) (
    input  logic               clk,
    input  logic               rst,
    tq_mode_dispatch_if.slave  bus,
    output logic               o_busy,
    output logic               o_err
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   cur_ch_q, cur_ch_d;
    logic [1:0]        cur_size_q, cur_size_d;
    logic [4:0]        row_cnt_q, row_cnt_d;
    logic              drop_q, drop_d;
    logic              err_q, err_d;
    logic              out_full_q, out_full_d;
    logic [CH_W-1:0]   out_ch_q, out_ch_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_last_q, out_last_d;

    logic [NUM_CH-1:0] valid_vec;
    logic              drain;
    logic              ready;
    logic              accept;
    logic              ch_illegal;
    logic [CH_W-1:0]   first_ch;
    logic              first_bad;
    logic [1:0]        beat_size;
    logic [5:0]        blk_rows;
    logic              beat_last;
    logic              beat_drop;

    assign ch_illegal = {1'b0, bus.i_ch} >= (CH_W+1)'(NUM_CH);

`ifdef TQ_DISPATCH_CHK_EN
    assign first_ch  = bus.i_ch;
    assign first_bad = ch_illegal;
`else
    assign first_ch  = ch_illegal ? CH_W'(NUM_CH - 1) : bus.i_ch;
    assign first_bad = 1'b0;
`endif

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            valid_vec[k] = out_full_q && (out_ch_q == CH_W'(k));
        end
    end

    // Only the engine owning the buffered row can free it; other readies never matter.
    assign drain  = |(valid_vec & bus.i_ready);
    assign ready  = !out_full_q || drain;
    assign accept = bus.i_valid && ready;

    assign beat_size = (state_q == IDLE) ? bus.i_size : cur_size_q;
    assign blk_rows  = 6'd4 << beat_size;
    assign beat_last = (state_q == RUN) && (row_cnt_q == 5'(blk_rows - 6'd1));
    assign beat_drop = (state_q == IDLE) ? first_bad : drop_q;

    always_comb begin
        state_d    = state_q;
        cur_ch_d   = cur_ch_q;
        cur_size_d = cur_size_q;
        row_cnt_d  = row_cnt_q;
        drop_d     = drop_q;
        err_d      = 1'b0;
        out_full_d = out_full_q;
        out_ch_d   = out_ch_q;
        out_data_d = out_data_q;
        out_last_d = out_last_q;

        if (accept) begin
            case (state_q)
                IDLE: begin
                    cur_ch_d   = first_ch;
                    cur_size_d = bus.i_size;
                    row_cnt_d  = 5'd1;
                    drop_d     = first_bad;
                    err_d      = first_bad;
                    state_d    = RUN;
                end
                RUN: begin
                    if (beat_last) begin
                        row_cnt_d = 5'd0;
                        drop_d    = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        row_cnt_d = row_cnt_q + 5'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // The channel tag rides with the row so consecutive blocks need no bubble.
        if (accept && !beat_drop) begin
            out_full_d = 1'b1;
            out_ch_d   = (state_q == IDLE) ? first_ch : cur_ch_q;
            out_data_d = bus.i_data;
            out_last_d = beat_last;
        end else if (drain) begin
            out_full_d = 1'b0;
            out_last_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cur_ch_q   <= '0;
            cur_size_q <= '0;
            row_cnt_q  <= '0;
            drop_q     <= 1'b0;
            err_q      <= 1'b0;
            out_full_q <= 1'b0;
            out_ch_q   <= '0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_ch_q   <= cur_ch_d;
            cur_size_q <= cur_size_d;
            row_cnt_q  <= row_cnt_d;
            drop_q     <= drop_d;
            err_q      <= err_d;
            out_full_q <= out_full_d;
            out_ch_q   <= out_ch_d;
            out_data_q <= out_data_d;
            out_last_q <= out_last_d;
        end
    end

    assign bus.o_valid = valid_vec;
    assign bus.o_ready = ready;
    assign bus.o_data  = out_data_q;
    assign bus.o_last  = out_last_q;
    assign o_busy      = (state_q == RUN) || out_full_q;
    assign o_err       = err_q;
endmodule
